// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the lane-parallel ALU pipeline: default geometry,
// the opcode encoding carried on i_op, and the control state encoding.
// No ports; imported by lane_op and alu_pipe.
// -----------------------------------------------------------------------------
package alu_pkg;

    // Default geometry: 64 lanes of Q15.16 fixed point, 80-bit dot accumulator.
    localparam int LANES_DEF = 64;
    localparam int W_DEF     = 32;
    localparam int FRAC_DEF  = 16;
    localparam int ACC_W_DEF = 80;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_MUL   = 3'b010,
        OP_RELU  = 3'b011,
        OP_BRELU = 3'b100,
        OP_MAX   = 3'b101,
        OP_DOT   = 3'b110,
        OP_ILL   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/lane_op.sv
// -----------------------------------------------------------------------------
// lane_op
// Purely combinational single-lane arithmetic for the element-wise opcodes.
// Also exposes the full-precision signed product so the parent can build the
// dot-product reduction without a second multiplier per lane.
// Ports:
//   i_op    opcode (alu_pkg::op_t)
//   i_a     signed lane operand a
//   i_b     signed lane operand b
//   o_res   element-wise result (zero for DOT / illegal)
//   o_prod  full 2W-bit signed product a*b
// -----------------------------------------------------------------------------
module lane_op
    import alu_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  op_t                  i_op,
    input  logic signed [W-1:0]   i_a,
    input  logic signed [W-1:0]   i_b,
    output logic signed [W-1:0]   o_res,
    output logic signed [2*W-1:0] o_prod
);

    logic signed [2*W-1:0] w_shifted;
    logic signed [W-1:0]   w_mulSat;
    logic                  w_fits;

    // Both operands are widened before multiplying so the 2W-bit product is exact.
    assign o_prod    = (2*W)'(i_a) * (2*W)'(i_b);
    assign w_shifted = o_prod >>> FRAC;

    // The rescaled product fits in W bits exactly when all bits from W-1
    // upward agree with the sign; otherwise clamp toward the sign's extreme.
    assign w_fits = (w_shifted[2*W-1:W-1] == '0) || (w_shifted[2*W-1:W-1] == '1);

    always_comb begin
        w_mulSat = w_shifted[W-1:0];
        if (!w_fits) begin
            w_mulSat = w_shifted[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    // Opcode select; DOT and illegal have no element-wise result.
    always_comb begin
        o_res = '0;
        case (i_op)
            OP_ADD:   o_res = i_a + i_b;
            OP_SUB:   o_res = i_a - i_b;
            OP_MUL:   o_res = w_mulSat;
            OP_RELU:  o_res = i_a[W-1] ? '0 : i_a;
            OP_BRELU: o_res = (!i_b[W-1] && (i_b != '0)) ? i_a : '0;
            OP_MAX:   o_res = (i_a > i_b) ? i_a : i_b;
            default:  o_res = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Lane-parallel ALU with a one-deep output register and a multi-beat dot
// product accumulator. Element-wise ops return one cycle after acceptance;
// DOT sequences accumulate lane-product sums until i_last, then present the
// total on o_acc with o_dot set.
// Ports:
//   iCLK, iRST          clock, synchronous active-high reset
//   i_valid / o_ready   operand beat handshake
//   i_op, i_last        opcode and DOT end-of-sequence marker
//   i_a, i_b            operand blocks, lane k at [k*W +: W]
//   o_valid / i_ready   result handshake
//   o_data              element-wise result block (zero for DOT results)
//   o_acc, o_dot        DOT result and its qualifier
//   o_err               one-cycle pulse for illegal / out-of-sequence beats
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int W     = W_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [2:0]         i_op,
    input  logic               i_last,
    input  logic [LANES*W-1:0] i_a,
    input  logic [LANES*W-1:0] i_b,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [LANES*W-1:0] o_data,
    output logic [ACC_W-1:0]   o_acc,
    output logic               o_dot,
    output logic               o_err
);

    // Reduction width rounded up to a power of two; spare leaves are zero.
    localparam int NP = (LANES <= 1) ? 1 : (1 << $clog2(LANES));

    op_t                   w_op;
    logic [LANES*W-1:0]    w_laneRes;
    logic signed [2*W-1:0] w_prod [LANES];
    logic signed [ACC_W-1:0] w_tree [NP];
    logic signed [ACC_W-1:0] w_laneSum;
    logic signed [ACC_W-1:0] w_accSum;
    logic                  w_accept;

    state_t                r_state, w_stateNext;
    logic signed [ACC_W-1:0] r_acc, w_accNext;
    logic [LANES*W-1:0]    r_data, w_dataNext;
    logic [ACC_W-1:0]      r_oAcc, w_oAccNext;
    logic                  r_dot, w_dotNext;
    logic                  r_err, w_errNext;

    assign w_op = op_t'(i_op);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_op #(
            .W    (W),
            .FRAC (FRAC)
        ) u_lane (
            .i_op   (w_op),
            .i_a    (i_a[k*W +: W]),
            .i_b    (i_b[k*W +: W]),
            .o_res  (w_laneRes[k*W +: W]),
            .o_prod (w_prod[k])
        );
    end

    // Pairwise adder tree over sign-extended lane products, folded in place
    // level by level; every add wraps at ACC_W bits.
    always_comb begin
        for (int n = 0; n < NP; n++) begin
            w_tree[n] = '0;
        end
        for (int n = 0; n < LANES; n++) begin
            w_tree[n] = ACC_W'(w_prod[n]);
        end
        for (int s = NP / 2; s >= 1; s = s / 2) begin
            for (int n = 0; n < s; n++) begin
                w_tree[n] = w_tree[2*n] + w_tree[2*n+1];
            end
        end
        w_laneSum = w_tree[0];
    end

    assign w_accSum = r_acc + w_laneSum;

    // In HOLD the upstream only sees ready when the held result is being taken,
    // so a beat accepted there simply replaces the result as if from IDLE.
    assign o_ready  = (r_state == ST_HOLD) ? i_ready : 1'b1;
    assign w_accept = i_valid && o_ready;

    // Next-state and next-output decode. A beat accepted in HOLD behaves like
    // one accepted in IDLE because the held result is consumed on that edge;
    // an illegal beat there therefore leaves the machine idle.
    always_comb begin
        w_stateNext = r_state;
        w_accNext   = r_acc;
        w_dataNext  = r_data;
        w_oAccNext  = r_oAcc;
        w_dotNext   = r_dot;
        w_errNext   = 1'b0;

        if ((r_state == ST_HOLD) && i_ready) begin
            w_stateNext = ST_IDLE;
        end

        if (w_accept) begin
            if (w_op == OP_ILL) begin
                w_errNext = 1'b1;
            end else if (r_state == ST_ACCUM) begin
                if (w_op == OP_DOT) begin
                    if (i_last) begin
                        w_oAccNext  = w_accSum;
                        w_dataNext  = '0;
                        w_dotNext   = 1'b1;
                        w_accNext   = '0;
                        w_stateNext = ST_HOLD;
                    end else begin
                        w_accNext = w_accSum;
                    end
                end else begin
                    w_errNext = 1'b1;
                end
            end else if (w_op == OP_DOT) begin
                if (i_last) begin
                    w_oAccNext  = w_laneSum;
                    w_dataNext  = '0;
                    w_dotNext   = 1'b1;
                    w_accNext   = '0;
                    w_stateNext = ST_HOLD;
                end else begin
                    w_accNext   = w_laneSum;
                    w_stateNext = ST_ACCUM;
                end
            end else begin
                w_dataNext  = w_laneRes;
                w_dotNext   = 1'b0;
                w_stateNext = ST_HOLD;
            end
        end
    end

    // Control state register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Datapath registers: partial sum, held result fields and the error pulse.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_acc  <= '0;
            r_data <= '0;
            r_oAcc <= '0;
            r_dot  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_acc  <= w_accNext;
            r_data <= w_dataNext;
            r_oAcc <= w_oAccNext;
            r_dot  <= w_dotNext;
            r_err  <= w_errNext;
        end
    end

    assign o_valid = (r_state == ST_HOLD);
    assign o_data  = r_data;
    assign o_acc   = r_oAcc;
    assign o_dot   = r_dot;
    assign o_err   = r_err;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Scoreboard bench for alu_pipe: the driver feeds beats into a lane-by-lane
// arithmetic reference model and queues the expected results; an independent
// monitor pops and compares whenever a new result is presented.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int LANES = 64;
    localparam int W     = 32;
    localparam int FRAC  = 16;
    localparam int ACC_W = 80;
    localparam int BW    = LANES * W;

    logic             iCLK;
    logic             iRST;
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_op;
    logic             i_last;
    logic [BW-1:0]    i_a;
    logic [BW-1:0]    i_b;
    logic             o_valid;
    logic             i_ready;
    logic [BW-1:0]    o_data;
    logic [ACC_W-1:0] o_acc;
    logic             o_dot;
    logic             o_err;

    typedef struct {
        logic             dot;
        logic [BW-1:0]    data;
        logic [ACC_W-1:0] acc;
    } exp_t;

    exp_t expQ[$];

    int checks  = 0;
    int errors  = 0;
    int errExp  = 0;
    int errSeen = 0;

    bit                      inDot;
    logic signed [ACC_W-1:0] partial;
    logic signed [ACC_W-1:0] lastAcc;

    bit               seen;
    logic             heldDot;
    logic [BW-1:0]    heldData;
    logic [ACC_W-1:0] heldAcc;
    bit               randReady = 1'b0;

    alu_pipe #(
        .LANES (LANES),
        .W     (W),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_last  (i_last),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_acc   (o_acc),
        .o_dot   (o_dot),
        .o_err   (o_err)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Downstream backpressure: random ready while enabled.
    always @(posedge iCLK) begin
        #1;
        if (randReady) i_ready = ($urandom_range(0, 1) == 1);
    end

    // Reference arithmetic for one lane, straight from the opcode definitions.
    function automatic logic [W-1:0] refLane(input int op, input logic signed [W-1:0] a,
                                            input logic signed [W-1:0] b);
        longint p;
        longint maxV;
        longint minV;
        maxV = (longint'(1) <<< (W - 1)) - 1;
        minV = -(longint'(1) <<< (W - 1));
        case (op)
            0: return a + b;
            1: return a - b;
            2: begin
                p = longint'(a) * longint'(b);
                p = p >>> FRAC;
                if (p > maxV) return W'(maxV);
                if (p < minV) return W'(minV);
                return W'(p);
            end
            3: return (a < 0) ? '0 : a;
            4: return (b > 0) ? a : '0;
            5: return (a > b) ? a : b;
            default: return '0;
        endcase
    endfunction

    function automatic logic signed [ACC_W-1:0] refDot(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic signed [ACC_W-1:0] s;
        logic signed [W-1:0]     ak;
        logic signed [W-1:0]     bk;
        s = '0;
        for (int k = 0; k < LANES; k++) begin
            ak = a[k*W +: W];
            bk = b[k*W +: W];
            s  = s + ACC_W'(longint'(ak) * longint'(bk));
        end
        return s;
    endfunction

    // Sequence-level model of an accepted beat.
    task automatic modelAccept(input int op, input logic [BW-1:0] a, input logic [BW-1:0] b,
                               input logic last);
        exp_t e;
        if (op == 7) begin
            errExp++;
        end else if (inDot) begin
            if (op == 6) begin
                partial = partial + refDot(a, b);
                if (last) begin
                    lastAcc = partial;
                    e.dot = 1'b1; e.data = '0; e.acc = lastAcc;
                    expQ.push_back(e);
                    inDot = 1'b0;
                    partial = '0;
                end
            end else begin
                errExp++;
            end
        end else if (op == 6) begin
            if (last) begin
                lastAcc = refDot(a, b);
                e.dot = 1'b1; e.data = '0; e.acc = lastAcc;
                expQ.push_back(e);
            end else begin
                partial = refDot(a, b);
                inDot = 1'b1;
            end
        end else begin
            e.dot = 1'b0;
            e.acc = lastAcc;
            for (int k = 0; k < LANES; k++) begin
                e.data[k*W +: W] = refLane(op, a[k*W +: W], b[k*W +: W]);
            end
            expQ.push_back(e);
        end
    endtask

    task automatic checkOutput(input string name, input logic [ACC_W-1:0] act,
                               input logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compareResult(input string name, input logic eDot, input logic [BW-1:0] eData,
                                 input logic [ACC_W-1:0] eAcc);
        int bad;
        checkOutput({name, "_dot"}, ACC_W'(o_dot), ACC_W'(eDot));
        bad = -1;
        for (int k = 0; k < LANES; k++) begin
            if (bad < 0 && o_data[k*W +: W] !== eData[k*W +: W]) bad = k;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL %s_data lane %0d: got 0x%0h expected 0x%0h",
                     name, bad, o_data[bad*W +: W], eData[bad*W +: W]);
        end
        checkOutput({name, "_acc"}, o_acc, eAcc);
    endtask

    // Monitor: a new result is checked against the queue head; while it is
    // held, it is checked for stability until the downstream handshake.
    always @(negedge iCLK) begin
        exp_t e;
        if (iRST) begin
            seen = 1'b0;
            expQ.delete();
        end else begin
            if (o_err) errSeen++;
            if (o_valid) begin
                if (!seen) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_result: got o_valid=1 expected no result");
                    end else begin
                        e = expQ.pop_front();
                        compareResult("result", e.dot, e.data, e.acc);
                    end
                    seen     = 1'b1;
                    heldDot  = o_dot;
                    heldData = o_data;
                    heldAcc  = o_acc;
                end else begin
                    compareResult("hold_stable", heldDot, heldData, heldAcc);
                end
                if (i_ready) seen = 1'b0;
            end
        end
    end

    // Present one beat from posedge+1, wait (bounded) for acceptance, feed the model.
    task automatic applyStimulus(input int op, input logic [BW-1:0] a, input logic [BW-1:0] b,
                                 input logic last, output int waited);
        i_valid = 1'b1;
        i_op    = op[2:0];
        i_a     = a;
        i_b     = b;
        i_last  = last;
        waited  = 0;
        @(negedge iCLK);
        while (!o_ready && waited < 50) begin
            waited++;
            @(negedge iCLK);
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got o_ready=0 expected 1 within 50 cycles");
        end else begin
            modelAccept(op, a, b, last);
        end
        @(posedge iCLK);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic resetDut();
        i_valid = 1'b1;
        i_op    = 3'b000;
        i_last  = 1'b0;
        i_ready = 1'b1;
        iRST    = 1'b1;
        repeat (2) @(posedge iCLK);
        #1;
        iRST    = 1'b0;
        i_valid = 1'b0;
        inDot   = 1'b0;
        partial = '0;
        lastAcc = '0;
        checkOutput("rst_o_valid", ACC_W'(o_valid), '0);
        checkOutput("rst_o_dot",   ACC_W'(o_dot), '0);
        checkOutput("rst_o_err",   ACC_W'(o_err), '0);
        checkOutput("rst_o_data",  ACC_W'(o_data != '0), '0);
        checkOutput("rst_o_acc",   o_acc, '0);
        checkOutput("rst_o_ready", ACC_W'(o_ready), ACC_W'(1));
    endtask

    task automatic drain();
        int cnt;
        randReady = 1'b0;
        i_ready   = 1'b1;
        cnt = 0;
        @(negedge iCLK);
        while ((expQ.size() != 0 || o_valid) && cnt < 100) begin
            cnt++;
            @(negedge iCLK);
        end
        if (cnt >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d results pending expected 0", expQ.size());
        end
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [BW-1:0] fillBlock(input logic [W-1:0] v);
        logic [BW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*W +: W] = v;
        return r;
    endfunction

    function automatic logic [BW-1:0] randBlock();
        logic [BW-1:0] r;
        for (int k = 0; k < LANES; k++) begin
            case ($urandom_range(0, 3))
                0: r[k*W +: W] = $urandom;
                1: r[k*W +: W] = W'($urandom_range(0, 200)) - W'(100);
                2: r[k*W +: W] = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
                default: r[k*W +: W] = W'($urandom_range(0, 32'h80000)) - W'(32'h40000);
            endcase
        end
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int errBase;
        int op;
        int r;
        logic [BW-1:0] a;
        logic [BW-1:0] b;

        i_valid = 1'b0;
        i_op    = '0;
        i_last  = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_ready = 1'b1;
        iRST    = 1'b1;
        @(posedge iCLK);
        #1;
        resetDut();

        // ADD 5 + -7 in every lane
        applyStimulus(0, fillBlock(32'd5), fillBlock(32'hFFFF_FFF9), 1'b0, waited);
        checkOutput("add_latency_valid", ACC_W'(o_valid), ACC_W'(1));
        checkOutput("add_lane0", ACC_W'(o_data[W-1:0]), ACC_W'(32'hFFFF_FFFE));
        checkOutput("add_dot", ACC_W'(o_dot), '0);
        drain();

        // MUL rescale and positive saturation
        applyStimulus(2, fillBlock(32'h0002_0000), fillBlock(32'h0001_8000), 1'b0, waited);
        checkOutput("mul_2x1p5", ACC_W'(o_data[W-1:0]), ACC_W'(32'h0003_0000));
        drain();
        applyStimulus(2, fillBlock(32'h7FFF_0000), fillBlock(32'h7FFF_0000), 1'b0, waited);
        checkOutput("mul_sat", ACC_W'(o_data[W-1:0]), ACC_W'(32'h7FFF_FFFF));
        drain();

        // Three-beat DOT, all 1 times all 2
        applyStimulus(6, fillBlock(32'd1), fillBlock(32'd2), 1'b0, waited);
        applyStimulus(6, fillBlock(32'd1), fillBlock(32'd2), 1'b0, waited);
        checkOutput("dot_mid_valid", ACC_W'(o_valid), '0);
        applyStimulus(6, fillBlock(32'd1), fillBlock(32'd2), 1'b1, waited);
        checkOutput("dot3_valid", ACC_W'(o_valid), ACC_W'(1));
        checkOutput("dot3_flag", ACC_W'(o_dot), ACC_W'(1));
        checkOutput("dot3_acc", o_acc, ACC_W'(384));
        drain();

        // Backpressure in HOLD, then a RELU beat accepted on the release cycle
        i_ready = 1'b0;
        applyStimulus(1, randBlock(), randBlock(), 1'b0, waited);
        repeat (4) begin
            @(negedge iCLK);
            checkOutput("hold_o_ready", ACC_W'(o_ready), '0);
            checkOutput("hold_o_valid", ACC_W'(o_valid), ACC_W'(1));
        end
        @(posedge iCLK);
        #1;
        i_ready = 1'b1;
        applyStimulus(3, fillBlock(32'hFFFF_FFFD), randBlock(), 1'b0, waited);
        checkOutput("hold_release_wait", ACC_W'(waited), '0);
        checkOutput("relu_neg3", ACC_W'(o_data[W-1:0]), '0);
        drain();

        // Out-of-sequence and illegal beats inside a DOT sequence
        errBase = errSeen;
        applyStimulus(6, randBlock(), randBlock(), 1'b0, waited);
        applyStimulus(1, randBlock(), randBlock(), 1'b0, waited);
        applyStimulus(7, randBlock(), randBlock(), 1'b0, waited);
        applyStimulus(6, randBlock(), randBlock(), 1'b1, waited);
        drain();
        checkOutput("accum_err_pulses", ACC_W'(errSeen - errBase), ACC_W'(2));

        // Reset in the middle of a DOT sequence
        applyStimulus(6, fillBlock(32'd3), fillBlock(32'd4), 1'b0, waited);
        applyStimulus(6, fillBlock(32'd3), fillBlock(32'd4), 1'b0, waited);
        resetDut();
        applyStimulus(6, fillBlock(32'd1), fillBlock(32'd1), 1'b1, waited);
        checkOutput("post_rst_dot_acc", o_acc, ACC_W'(64));
        drain();

        // Randomized mix with random backpressure and idle gaps
        randReady = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge iCLK);
                #1;
            end
            r = $urandom_range(0, 9);
            op = (r <= 5) ? r : ((r <= 8) ? 6 : 7);
            a = randBlock();
            b = randBlock();
            applyStimulus(op, a, b, ($urandom_range(0, 2) == 0), waited);
        end
        if (inDot) applyStimulus(6, randBlock(), randBlock(), 1'b1, waited);
        drain();
        checkOutput("err_total", ACC_W'(errSeen), ACC_W'(errExp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter LANES, default 64, number of 32-bit-class lanes per block.
REQ-002 Parameter W, default 32, signed lane width (two's complement).
REQ-003 Parameter FRAC, default 16, fractional bits used by MUL rescale.
REQ-004 Parameter ACC_W, default 80, signed dot-product accumulator width; ACC_W >= 2*W.
REQ-005 iCLK  in  1  sole clock, all logic rising-edge.
REQ-006 iRST  in  1  synchronous active-high reset.
REQ-007 i_valid  in  1  operand beat present.
REQ-008 o_ready  out  1  beat accepted on i_valid&&o_ready.
REQ-009 i_op  in  3  opcode: 000 ADD, 001 SUB (a-b), 010 MUL, 011 RELU(a), 100 BRELU (a where b>0 else 0), 101 MAX, 110 DOT, 111 illegal.
REQ-010 i_last  in  1  final beat of a DOT sequence; ignored for other ops.
REQ-011 i_a, i_b  in  LANES*W each  operand blocks, lane k at bits [k*W +: W].
REQ-012 o_valid  out  1  result present.
REQ-013 i_ready  in  1  downstream accepts on o_valid&&i_ready.
REQ-014 o_data  out  LANES*W  element-wise result.
REQ-015 o_acc  out  ACC_W  DOT result; o_dot high marks o_acc as the valid field.
REQ-016 o_dot  out  1  current result is DOT.
REQ-017 o_err  out  1  one-cycle pulse on illegal or out-of-sequence op.

Function
REQ-018 States IDLE, ACCUM, HOLD; exactly one active.
REQ-019 IDLE: o_ready=1; accepted element-wise op -> result registered, o_valid=1 next cycle, go HOLD.
REQ-020 IDLE: accepted DOT with i_last=0 -> acc := sum of lane products, go ACCUM; with i_last=1 -> result to o_acc, go HOLD.
REQ-021 ACCUM: o_ready=1; DOT beat adds its lane-product sum to acc; on i_last go HOLD with o_acc=final sum.
REQ-022 ACCUM: accepted non-DOT op is discarded, o_err pulses, acc and state unchanged.
REQ-023 HOLD: o_valid=1, outputs stable; o_ready=i_ready; on i_ready a new beat may be accepted same cycle and is treated as from IDLE; with no beat go IDLE.
REQ-024 Element-wise latency exactly 1 cycle accept-to-o_valid; DOT latency 1 cycle after last beat accepted.
REQ-025 ADD/SUB wrap modulo 2^W; MAX signed compare.
REQ-026 MUL: full 2W signed product, arithmetic right shift FRAC, saturate to W-bit signed range.
REQ-027 DOT: each product full 2W signed, lane sum and accumulation wrap modulo 2^ACC_W.
REQ-028 Illegal op 111 in any accepting state: beat consumed, o_err pulses, no result, state unchanged.
REQ-029 When o_dot=1, o_data is zero; when o_dot=0, o_acc holds its previous value.
REQ-030 i_valid=0 in any state leaves acc and outputs unchanged.

Reset
REQ-031 iRST sampled high: state IDLE, acc=0, o_valid=0, o_dot=0, o_err=0, o_data=0, o_acc=0 next edge, regardless of state or pending beat.
REQ-032 Reset mid-DOT or during HOLD discards partial sum and held result; first post-reset cycle has o_ready=1.

Structure
REQ-033 Opcode enum, state enum and default LANES/W/FRAC/ACC_W live in shared package alu_pkg.
REQ-034 One sub-module lane_op (single-lane ADD/SUB/MUL/RELU/BRELU/MAX, combinational), instantiated LANES times via generate.
REQ-035 Product reduction for DOT is a combinational adder tree inside alu_pipe.

Verification
REQ-036 ADD a=all 5, b=all -7 -> next cycle o_valid=1, every lane -2, o_dot=0.
REQ-037 MUL FRAC=16, a=0x0002_0000 (2.0), b=0x0001_8000 (1.5) -> lane 0x0003_0000; a=b=0x7FFF_0000 -> 0x7FFF_FFFF saturated.
REQ-038 DOT 3 beats, a=all 1, b=all 2, last on beat 3, LANES=64 -> o_acc=384, o_dot=1, one cycle after beat 3.
REQ-039 HOLD with i_ready=0 for 4 cycles -> o_valid and o_data stable, o_ready=0; then i_ready=1 with new RELU beat a=-3 -> accepted same cycle, next result 0.
REQ-040 In ACCUM send SUB then op 111 -> o_err pulses twice, final DOT sum unaffected.
REQ-041 iRST asserted after 2 DOT beats -> o_valid=0, acc=0; new single-beat DOT a=b=all 1 -> o_acc=64.
